// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with a two-entry skid buffer,
// synchronous flush and a saturating bubble counter.
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  parameter logic [DATA_W-1:0] RST_DATA = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t             r_state;
  logic [DATA_W-1:0]  r_main;
  logic [DATA_W-1:0]  r_skid;
  logic [CNT_W-1:0]   r_cnt;
  // Handshake outputs come straight from the state flops, so ready never depends on out_ready.
  assign out_valid  = r_state != EMPTY;
  assign in_ready   = r_state != FULL;
  assign occupancy  = r_state == FULL ? 2'd2 : r_state == ONE ? 2'd1 : 2'd0;
  assign out_data   = r_main;
  assign bubble_cnt = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= RST_DATA;
      r_skid  <= RST_DATA;
      r_cnt   <= '0;
    end else begin
      r_cnt <= cnt_clr ? '0 :
               (out_ready && r_state == EMPTY && !flush && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
      if (flush) begin
        r_state <= EMPTY;
        r_main  <= RST_DATA;
        r_skid  <= RST_DATA;
      end else begin
        case (r_state)
          EMPTY: if (in_valid) begin
            r_main  <= in_data;
            r_state <= ONE;
          end
          ONE: if (in_valid && out_ready) r_main <= in_data;
          else if (out_ready) r_state <= EMPTY;
          else if (in_valid) begin
            r_skid  <= in_data;
            r_state <= FULL;
          end
          FULL: if (out_ready) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
          default: r_state <= EMPTY;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and randomised checks of pipe_skid_stage against hand-computed values and a queue model.
module tb_pipe_skid_stage;
  localparam int DW = 32;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready, cnt_clr;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] bubble_cnt;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] q[$];
  int            m_cnt;

  pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic v, input logic r, input logic [1:0] occ, input logic [DW-1:0] d);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, r});
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
    if (v) chk({tag, ".out_data"}, out_data, d);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0; cnt_clr = 1'b0;
    step(); step();
    chk_state("reset", 1'b0, 1'b1, 2'd0, '0);
    chk("reset.out_data", out_data, 32'h0);
    chk("reset.bubble", {28'd0, bubble_cnt}, 32'd0);
    // streaming
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
    step(); chk_state("stream1", 1'b1, 1'b1, 2'd1, 32'h1);
    in_data = 32'h2;
    step(); chk_state("stream2", 1'b1, 1'b1, 2'd1, 32'h2);
    in_data = 32'h3;
    step(); chk_state("stream3", 1'b1, 1'b1, 2'd1, 32'h3);
    in_valid = 1'b0;
    step(); chk_state("stream_drain", 1'b0, 1'b1, 2'd0, '0);
    // back-pressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step(); chk_state("bp_a", 1'b1, 1'b1, 2'd1, 32'hA);
    in_data = 32'hB;
    step(); chk_state("bp_full", 1'b1, 1'b0, 2'd2, 32'hA);
    in_data = 32'hC;
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("bp_hold", 1'b1, 1'b0, 2'd2, 32'hA);
    end
    out_ready = 1'b1;
    step(); chk_state("bp_out_b", 1'b1, 1'b1, 2'd1, 32'hB);
    step(); chk_state("bp_out_c", 1'b1, 1'b1, 2'd1, 32'hC);
    in_valid = 1'b0;
    step(); chk_state("bp_drain", 1'b0, 1'b1, 2'd0, '0);
    // flush while full with a beat offered in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step(); in_data = 32'hB;
    step(); chk_state("fl_full", 1'b1, 1'b0, 2'd2, 32'hA);
    flush = 1'b1; in_data = 32'hC;
    step(); flush = 1'b0; in_valid = 1'b0;
    chk_state("fl_empty", 1'b0, 1'b1, 2'd0, '0);
    chk("fl.out_data", out_data, 32'h0);
    step(); chk_state("fl_no_c", 1'b0, 1'b1, 2'd0, '0);
    in_valid = 1'b1; in_data = 32'h5;
    step(); chk_state("fl_next", 1'b1, 1'b1, 2'd1, 32'h5);
    in_valid = 1'b0; out_ready = 1'b1;
    step(); chk_state("fl_next_drain", 1'b0, 1'b1, 2'd0, '0);
    // bubble counter: clear beats a simultaneous qualifying cycle
    cnt_clr = 1'b1;
    step(); chk("bub_clr_qual", {28'd0, bubble_cnt}, 32'd0);
    cnt_clr = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(); chk("bub_count", {28'd0, bubble_cnt}, (i > 15) ? 32'd15 : 32'(i));
    end
    out_ready = 1'b0; cnt_clr = 1'b1;
    step(); chk("bub_clr", {28'd0, bubble_cnt}, 32'd0);
    cnt_clr = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("bub_three", {28'd0, bubble_cnt}, 32'd3);
    flush = 1'b1;
    step(); flush = 1'b0;
    chk("bub_flush_keep", {28'd0, bubble_cnt}, 32'd3);
    // random traffic against a queue model
    out_ready = 1'b0;
    step();
    q.delete();
    m_cnt = 3;
    for (int i = 0; i < 10000; i++) begin
      chk("rnd.out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("rnd.in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("rnd.occupancy", {30'd0, occupancy}, 32'(q.size()));
      if (q.size() != 0) chk("rnd.out_data", out_data, q[0]);
      chk("rnd.bubble", {28'd0, bubble_cnt}, 32'(m_cnt));
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 49) == 0;
      cnt_clr = $urandom_range(0, 99) == 0;
      in_data = $urandom;
      if (cnt_clr) m_cnt = 0;
      else if (out_ready && q.size() == 0 && !flush && m_cnt < 15) m_cnt++;
      if (flush) q.delete();
      else begin
        logic rdy;
        rdy = q.size() < 2;
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && rdy) q.push_back(in_data);
      end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
